adrv9001_enable_seq: RTL and testbench



---
 rtl/adrv9001_pkg.sv | 16 +
 rtl/adrv9001_delay_cnt.sv | 36 +++
 rtl/adrv9001_enable_seq.sv | 150 +++++++++++++++
 tb/tb_adrv9001_enable_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_pkg.sv
// adrv9001_pkg
//   Shared definitions for the ADRV9001 channel enable sequencer:
//   sequencer state encodings (also exported on seq_state) and the
//   default delay-counter width.
package adrv9001_pkg;

   localparam int DEF_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      SEQ_IDLE     = 2'd0,
      SEQ_ASSERT   = 2'd1,
      SEQ_ACTIVE   = 2'd2,
      SEQ_DEASSERT = 2'd3
   } seq_state_t;

endpackage

// File: rtl/adrv9001_delay_cnt.sv
// adrv9001_delay_cnt
//   Loadable down-counter used to time the enable/disable delays.
//   Load has priority over decrement; the count stops at zero (no wrap).
// Ports
//   clk       in   1          clock
//   rst       in   1          asynchronous, active-high reset (count -> 0)
//   load      in   1          load load_val
//   dec       in   1          decrement (ignored when already zero)
//   load_val  in   CNT_WIDTH  value loaded on load
//   zero      out  1          count is zero
module adrv9001_delay_cnt
   import adrv9001_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 dec,
   input  logic [CNT_WIDTH-1:0] load_val,
   output logic                 zero
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                count <= '0;
      else if (load)          count <= load_val;
      else if (dec && !zero)  count <= count - CNT_ONE;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/adrv9001_enable_seq.sv
// adrv9001_enable_seq
//   Per-channel enable sequencer for one ADRV9001 TX/RX channel. Picks the
//   enable request from software (ps_enable, synchronised) or fabric
//   (pl_enable, already in clk domain), drives the transceiver enable pin and
//   gates the datapath with programmable enable/disable delays.
// Configuration
//   ADRV9001_ENABLE_SEQ_STATS_EN : build the ACTIVE-cycle / burst statistics.
//                                  Undefined -> stats outputs tied to 0.
// Ports
//   clk            in   1          channel datapath clock
//   rst            in   1          asynchronous, active-high reset
//   enable_mode    in   1          0 = ps_enable, 1 = pl_enable (AXI domain)
//   ps_enable      in   1          software enable request (AXI domain)
//   pl_enable      in   1          fabric enable request (clk domain)
//   enable_delay   in   CNT_WIDTH  ch_enable rise -> data_enable rise, minus 1
//   disable_delay  in   CNT_WIDTH  data_enable fall -> ch_enable fall, minus 1
//   ch_enable      out  1          enable pin to ADRV9001
//   data_enable    out  1          datapath valid gate
//   busy           out  1          sequencer not idle
//   seq_state      out  2          current state encoding
//   active_cycles  out  32         cycles spent in ACTIVE (saturating)
//   burst_count    out  16         completed ACTIVE bursts (wrapping)
module adrv9001_enable_seq
   import adrv9001_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_mode,
   input  logic                 ps_enable,
   input  logic                 pl_enable,
   input  logic [CNT_WIDTH-1:0] enable_delay,
   input  logic [CNT_WIDTH-1:0] disable_delay,
   output logic                 ch_enable,
   output logic                 data_enable,
   output logic                 busy,
   output logic [1:0]           seq_state,
   output logic [31:0]          active_cycles,
   output logic [15:0]          burst_count
);

   // Per-bit synchroniser chains: bit 0 = ps_enable, bit 1 = enable_mode.
   logic [1:0]                  async_in;
   logic [1:0][SYNC_STAGES-1:0] sync_q;

   assign async_in = {enable_mode, ps_enable};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         for (int b = 0; b < 2; b++)
            sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], async_in[b]};
      end
   end

   logic req;
   assign req = sync_q[1][SYNC_STAGES-1] ? pl_enable : sync_q[0][SYNC_STAGES-1];

   seq_state_t           state, nxt;
   logic                 cnt_load, cnt_dec, cnt_zero;
   logic [CNT_WIDTH-1:0] cnt_val;

   adrv9001_delay_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_delay_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   // Transition and counter control. A dropped request during ASSERT aborts
   // straight into DEASSERT, so data_enable never rises for that sequence.
   // DEASSERT ignores req; it always finishes through one IDLE cycle.
   always_comb begin
      nxt      = state;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = enable_delay;
      case (state)
         SEQ_IDLE: begin
            if (req) begin
               nxt      = SEQ_ASSERT;
               cnt_load = 1'b1;
            end
         end
         SEQ_ASSERT: begin
            if (!req) begin
               nxt      = SEQ_DEASSERT;
               cnt_load = 1'b1;
               cnt_val  = disable_delay;
            end else if (cnt_zero) begin
               nxt = SEQ_ACTIVE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         SEQ_ACTIVE: begin
            if (!req) begin
               nxt      = SEQ_DEASSERT;
               cnt_load = 1'b1;
               cnt_val  = disable_delay;
            end
         end
         SEQ_DEASSERT: begin
            if (cnt_zero) nxt = SEQ_IDLE;
            else          cnt_dec = 1'b1;
         end
         default: nxt = SEQ_IDLE;
      endcase
   end

   // Outputs decoded from the next state so they line up with the state reg.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SEQ_IDLE;
         ch_enable   <= 1'b0;
         data_enable <= 1'b0;
         busy        <= 1'b0;
         seq_state   <= 2'd0;
      end else begin
         state       <= nxt;
         ch_enable   <= (nxt != SEQ_IDLE);
         data_enable <= (nxt == SEQ_ACTIVE);
         busy        <= (nxt != SEQ_IDLE);
         seq_state   <= nxt;
      end
   end

`ifdef ADRV9001_ENABLE_SEQ_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_cycles <= '0;
         burst_count   <= '0;
      end else begin
         if (state == SEQ_ACTIVE && active_cycles != 32'hFFFF_FFFF)
            active_cycles <= active_cycles + 32'd1;
         if (state == SEQ_ACTIVE && nxt == SEQ_DEASSERT)
            burst_count <= burst_count + 16'd1;
      end
   end
`else
   assign active_cycles = '0;
   assign burst_count   = '0;
`endif

endmodule

// File: tb/tb_adrv9001_enable_seq.sv
// Bench for adrv9001_enable_seq. A timestamp-based model predicts the outputs
// from the request history and is compared every cycle; directed sequences
// add hand-computed literal checks at the documented timing points.
module tb_adrv9001_enable_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_mode = 1'b0;
   logic        ps_enable = 1'b0;
   logic        pl_enable = 1'b0;
   logic [15:0] enable_delay = '0;
   logic [15:0] disable_delay = '0;
   logic        ch_enable, data_enable, busy;
   logic [1:0]  seq_state;
   logic [31:0] active_cycles;
   logic [15:0] burst_count;

   adrv9001_enable_seq #(.CNT_WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable_mode   (enable_mode),
      .ps_enable     (ps_enable),
      .pl_enable     (pl_enable),
      .enable_delay  (enable_delay),
      .disable_delay (disable_delay),
      .ch_enable     (ch_enable),
      .data_enable   (data_enable),
      .busy          (busy),
      .seq_state     (seq_state),
      .active_cycles (active_cycles),
      .burst_count   (burst_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

`ifdef ADRV9001_ENABLE_SEQ_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   // ---------------- model ----------------
   // Edge-numbered timeline: a sequence started at edge k raises data at edge
   // k+D+1; a request drop at edge j schedules ch_enable off at edge j+E+1.
   int      e = 0;
   bit      m_ch = 0, m_data = 0;
   int      m_data_edge = 0, m_off_edge = -1;
   bit [1:0] ps_d = '0, mode_d = '0;
   longint  m_act = 0;
   int      m_burst = 0;

   always @(posedge clk) begin : model_and_compare
      bit r;
      logic [1:0]  exp_st;
      logic [31:0] exp_act;
      logic [15:0] exp_burst;
      if (rst) begin
         m_ch = 0; m_data = 0; m_off_edge = -1;
         ps_d = '0; mode_d = '0; m_act = 0; m_burst = 0;
      end else begin
         e++;
         r = mode_d[1] ? pl_enable : ps_d[1];
         ps_d   = {ps_d[0], ps_enable};
         mode_d = {mode_d[0], enable_mode};
         if (m_data) m_act++;
         if (!m_ch) begin
            if (r) begin
               m_ch = 1; m_data_edge = e + int'(enable_delay) + 1; m_off_edge = -1;
            end
         end else if (m_off_edge >= 0) begin
            if (e == m_off_edge) begin m_ch = 0; m_off_edge = -1; end
         end else if (!m_data) begin
            if (!r) m_off_edge = e + int'(disable_delay) + 1;
            else if (e == m_data_edge) m_data = 1;
         end else if (!r) begin
            m_data = 0; m_off_edge = e + int'(disable_delay) + 1; m_burst++;
         end
      end
      #1;
      exp_st    = !m_ch ? 2'd0 : (m_off_edge >= 0) ? 2'd3 : m_data ? 2'd2 : 2'd1;
      exp_act   = STATS ? ((m_act > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_act)) : 32'd0;
      exp_burst = STATS ? 16'(m_burst) : 16'd0;
      check("m_ch_enable",   64'(ch_enable),     64'(m_ch));
      check("m_data_enable", 64'(data_enable),   64'(m_data));
      check("m_busy",        64'(busy),          64'(m_ch));
      check("m_seq_state",   64'(seq_state),     64'(exp_st));
      check("m_active",      64'(active_cycles), 64'(exp_act));
      check("m_burst",       64'(burst_count),   64'(exp_burst));
   end

   // ---------------- directed literal checks ----------------
   task automatic wait_chk(input int n, input logic ch, input logic de,
                           input logic [1:0] st, input string nm);
      repeat (n) @(posedge clk);
      #2;
      check({nm, "_ch"},    64'(ch_enable),   64'(ch));
      check({nm, "_data"},  64'(data_enable), 64'(de));
      check({nm, "_state"}, 64'(seq_state),   64'(st));
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // reset state
      enable_mode = 1'b1;
      #3;
      check("rst_ch",    64'(ch_enable),     64'd0);
      check("rst_data",  64'(data_enable),   64'd0);
      check("rst_busy",  64'(busy),          64'd0);
      check("rst_state", 64'(seq_state),     64'd0);
      check("rst_act",   64'(active_cycles), 64'd0);
      check("rst_burst", 64'(burst_count),   64'd0);
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(3);

      // pl mode, D=10, E=5, 50-cycle request
      enable_delay = 16'd10; disable_delay = 16'd5;
      @(negedge clk); pl_enable = 1'b1;
      wait_chk(1,  1'b1, 1'b0, 2'd1, "t1_rise");
      wait_chk(10, 1'b1, 1'b0, 2'd1, "t1_pre_data");
      wait_chk(1,  1'b1, 1'b1, 2'd2, "t1_data_on");
      idle_cycles(38);
      pl_enable = 1'b0;
      wait_chk(1,  1'b1, 1'b0, 2'd3, "t1_data_off");
      wait_chk(5,  1'b1, 1'b0, 2'd3, "t1_pre_off");
      wait_chk(1,  1'b0, 1'b0, 2'd0, "t1_ch_off");
      idle_cycles(3);

      // delays 0/0, single-cycle pulse: abort from ASSERT
      enable_delay = 16'd0; disable_delay = 16'd0;
      @(negedge clk); pl_enable = 1'b1;
      wait_chk(1, 1'b1, 1'b0, 2'd1, "t2_assert");
      @(negedge clk); pl_enable = 1'b0;
      wait_chk(1, 1'b1, 1'b0, 2'd3, "t2_deassert");
      wait_chk(1, 1'b0, 1'b0, 2'd0, "t2_idle");
      idle_cycles(3);

      // long enable delay, abort after 40 ASSERT cycles; mid-count delay change
      enable_delay = 16'd100; disable_delay = 16'd5;
      @(negedge clk); pl_enable = 1'b1;
      idle_cycles(5);
      enable_delay = 16'd3;
      idle_cycles(35);
      pl_enable = 1'b0;
      wait_chk(1, 1'b1, 1'b0, 2'd3, "t3_abort");
      wait_chk(5, 1'b1, 1'b0, 2'd3, "t3_pre_off");
      wait_chk(1, 1'b0, 1'b0, 2'd0, "t3_ch_off");
      idle_cycles(3);

      // ps mode: pl ignored, 3-cycle synchroniser + FSM latency
      enable_delay = 16'd2; disable_delay = 16'd1;
      @(negedge clk); enable_mode = 1'b0;
      idle_cycles(3);
      pl_enable = 1'b1;
      wait_chk(5, 1'b0, 1'b0, 2'd0, "t4_pl_ignored");
      @(negedge clk); pl_enable = 1'b0; ps_enable = 1'b1;
      wait_chk(2, 1'b0, 1'b0, 2'd0, "t4_sync_wait");
      wait_chk(1, 1'b1, 1'b0, 2'd1, "t4_ps_rise");
      idle_cycles(10);
      ps_enable = 1'b0;
      idle_cycles(8);

      // reset while ACTIVE
      enable_mode = 1'b1;
      idle_cycles(3);
      enable_delay = 16'd3; disable_delay = 16'd2;
      pl_enable = 1'b1;
      wait_chk(10, 1'b1, 1'b1, 2'd2, "t5_active");
      @(negedge clk); rst = 1'b1;
      #1;
      check("t5_async_ch",    64'(ch_enable),     64'd0);
      check("t5_async_data",  64'(data_enable),   64'd0);
      check("t5_async_busy",  64'(busy),          64'd0);
      check("t5_async_state", 64'(seq_state),     64'd0);
      check("t5_async_act",   64'(active_cycles), 64'd0);
      check("t5_async_burst", 64'(burst_count),   64'd0);
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(12);
      pl_enable = 1'b0;
      idle_cycles(8);

      // three bursts of 20 ACTIVE cycles
      do_reset();
      idle_cycles(3);
      enable_delay = 16'd2; disable_delay = 16'd2;
      for (int b = 0; b < 3; b++) begin
         pl_enable = 1'b1;
         idle_cycles(23);
         pl_enable = 1'b0;
         idle_cycles(6);
      end
      #2;
      check("t6_burst",  64'(burst_count),   STATS ? 64'd3  : 64'd0);
      check("t6_active", 64'(active_cycles), STATS ? 64'd60 : 64'd0);
      idle_cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
